// File: rtl/output_accum_buffer.sv
// Output buffer for the systolic array: captures the column-skewed result stream
// into per-column banks (overwrite or saturating accumulate) and drains row vectors.
module output_accum_buffer #(
  parameter int COLS      = 8,
  parameter int ROWS      = 8,
  parameter int DATA_W    = 32,
  parameter int DSP_DELAY = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   acc_mode,
  input  logic                   in_valid,
  input  logic [COLS*DATA_W-1:0] in_res,
  input  logic                   drain_req,
  input  logic                   drain_clear,
  input  logic                   clear,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COLS*DATA_W-1:0] out_data,
  output logic                   out_last,
  output logic                   busy,
  output logic                   load_done,
  output logic                   sat_flag
);

  localparam int L  = (COLS - 1) * DSP_DELAY + ROWS;
  localparam int TW = (L > 1) ? $clog2(L) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  state_t                 state_reg, state_next;
  logic [TW-1:0]          t_reg;
  logic [RW-1:0]          p_reg;
  logic [RW-1:0]          rd_ptr;
  logic                   acc_reg;
  logic                   dclr_reg;
  logic                   out_valid_reg;
  logic [COLS*DATA_W-1:0] out_data_reg;
  logic                   out_last_reg;
  logic                   load_done_reg;
  logic                   sat_reg;

  logic                   beat;
  logic                   last_beat;
  logic                   hs;
  logic                   clr_all;
  logic                   drain_zero;
  logic [COLS*DATA_W-1:0] row_vec;
  logic [COLS-1:0]        col_sat;

  assign beat       = (state_reg == LOAD) && in_valid;
  assign last_beat  = (t_reg == TW'(L - 1));
  assign hs         = (state_reg == DRAIN) && out_valid_reg && out_ready;
  assign clr_all    = (state_reg == IDLE) && clear && !start && !drain_req;
  assign drain_zero = hs && dclr_reg;

  // Row to present next: the current row until the first beat is out, then the following one.
  always_comb begin
    rd_ptr = p_reg;
    if (out_valid_reg && (p_reg != RW'(ROWS - 1)))
      rd_ptr = p_reg + RW'(1);
  end

  genvar gi;
  generate
    for (gi = 0; gi < COLS; gi++) begin : g_col
      localparam int OFF = gi * DSP_DELAY;

      logic [DATA_W-1:0] mem [ROWS];
      logic [DATA_W-1:0] col_in;
      logic [31:0]       row_off;
      logic              cap;
      logic [RW-1:0]     wr_row;
      logic [DATA_W:0]   sum;
      logic              ovf;
      logic [DATA_W-1:0] acc_val;

      assign col_in  = in_res[gi*DATA_W +: DATA_W];
      // Beats before this column's window wrap to a huge offset, so one compare covers both bounds.
      assign row_off = 32'(t_reg) - 32'(OFF);
      assign cap     = beat && (row_off < 32'(ROWS));
      assign wr_row  = row_off[RW-1:0];

      assign sum     = {mem[wr_row][DATA_W-1], mem[wr_row]} + {col_in[DATA_W-1], col_in};
      assign ovf     = sum[DATA_W] ^ sum[DATA_W-1];
      assign acc_val = !ovf ? sum[DATA_W-1:0] :
                       (sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}});

      assign col_sat[gi]                   = cap && acc_reg && ovf;
      assign row_vec[gi*DATA_W +: DATA_W]  = mem[rd_ptr];

      always_ff @(posedge clk) begin
        if (rst || clr_all) begin
          for (int r = 0; r < ROWS; r++)
            mem[r] <= '0;
        end else begin
          if (cap)
            mem[wr_row] <= acc_reg ? acc_val : col_in;
          if (drain_zero)
            mem[p_reg] <= '0;
        end
      end
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (start)
          state_next = LOAD;
        else if (drain_req)
          state_next = DRAIN;
      end
      LOAD:    if (beat && last_beat) state_next = IDLE;
      DRAIN:   if (hs && out_last_reg) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      t_reg         <= '0;
      p_reg         <= '0;
      acc_reg       <= 1'b0;
      dclr_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
      load_done_reg <= 1'b0;
      sat_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      load_done_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (start) begin
            acc_reg <= acc_mode;
            t_reg   <= '0;
          end else if (drain_req) begin
            dclr_reg <= drain_clear;
            p_reg    <= '0;
          end else if (clear) begin
            sat_reg <= 1'b0;
          end
        end
        LOAD: begin
          if (beat) begin
            if (last_beat) begin
              t_reg         <= '0;
              load_done_reg <= 1'b1;
            end else begin
              t_reg <= t_reg + TW'(1);
            end
          end
          if (|col_sat)
            sat_reg <= 1'b1;
        end
        DRAIN: begin
          if (hs && out_last_reg) begin
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
          end else if (!out_valid_reg || hs) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= row_vec;
            out_last_reg  <= (rd_ptr == RW'(ROWS - 1));
            p_reg         <= rd_ptr;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;
  assign busy      = (state_reg != IDLE);
  assign load_done = load_done_reg;
  assign sat_flag  = sat_reg;

endmodule

// File: doc/output_accum_buffer.md
# output_accum_buffer

Parametrised output buffer for the systolic array. It captures the column-skewed result stream from the PE array into per-column banks of ROWS entries. Each capture either overwrites or saturating-accumulates the stored value, so partial sums can build up over several K-tiles. Finished tiles drain as row vectors over a valid/ready stream toward the result writer. It replaces the fixed-size shift-register output buffer: width, depth and skew are parameters, and it adds accumulate, clear, saturation and back-pressured drain.

## Interface
- COLS, 8: number of array columns / banks
- ROWS, 8: entries per bank (tile height)
- DATA_W, 32: signed result width
- DSP_DELAY, 3: cycles of skew between adjacent columns (≥1)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin LOAD phase (sampled in IDLE only)
- acc_mode  in  1  sampled with start: 0 = overwrite, 1 = accumulate
- in_valid  in  1  in_res beat valid; advances load counter
- in_res  in  COLS*DATA_W  column results, column c at bits [(c+1)*DATA_W-1 : c*DATA_W]
- drain_req  in  1  begin DRAIN phase (sampled in IDLE only)
- drain_clear  in  1  sampled with drain_req: zero each row after it drains
- clear  in  1  zero all banks (IDLE only)
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data
- out_data  out  COLS*DATA_W  one row vector, same column packing as in_res
- out_last  out  1  marks row ROWS-1
- busy  out  1  state ≠ IDLE
- load_done  out  1  one-cycle pulse at end of LOAD
- sat_flag  out  1  sticky: an accumulate saturated

## Operation
- FSM states are IDLE, LOAD and DRAIN.
- IDLE → LOAD on start. IDLE → DRAIN on drain_req when start is low; start wins if both are high.
- LOAD → IDLE after the last capture beat. DRAIN → IDLE after the out_last handshake.
- clear is honoured only in IDLE with start and drain_req low. It zeros all banks and sat_flag.
- LOAD: beat counter t starts at 0 and increments on each in_valid cycle. in_valid low stalls the counter and captures nothing.
- On a valid beat, column c captures when c*DSP_DELAY ≤ t < c*DSP_DELAY+ROWS, into row r = t − c*DSP_DELAY.
- Total beats L = (COLS−1)*DSP_DELAY + ROWS. On beat t = L−1, LOAD ends and load_done pulses next cycle.
- Overwrite mode: bank[c][r] ← in value.
- Accumulate mode: sum = bank + in computed at DATA_W+1 bits, then clamped to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- Any clamp sets sat_flag. sat_flag clears only on rst or clear.
- DRAIN: row pointer p starts at 0. out_data = {bank[COLS−1][p] … bank[0][p]}. out_last = (p == ROWS−1).
- A handshake (out_valid & out_ready) advances p. If drain_clear was set, the handshake also zeroes row p in all banks.
- start, drain_req and clear outside IDLE are ignored; no queuing.
- Bank contents persist across IDLE until they are overwritten, accumulated or cleared.

## Timing
- Reset values: state IDLE, banks 0, out_valid 0, out_data 0, out_last 0, busy 0, load_done 0, sat_flag 0, t 0, p 0.
- rst in any state takes effect at the next edge and aborts LOAD or DRAIN mid-tile. No load_done is generated.
- busy goes high the cycle after start or drain_req is sampled.
- Capture is registered: a beat at edge n is visible in the bank at n+1.
- The first out_valid appears one cycle after DRAIN entry. Rows then stream at 1/cycle while out_ready stays high.
- out_data and out_last are registered and hold stable while out_valid & !out_ready.
- After the out_last handshake, out_valid drops next cycle and the FSM is in IDLE. A new start is accepted on that IDLE cycle.
- Minimum tile time is L+1 cycles LOAD plus ROWS+1 cycles DRAIN. There is no overlap between LOAD and DRAIN.

## Test plan
All scenarios use COLS=4, ROWS=4, DATA_W=16, DSP_DELAY=2, so L=10.
- **Reset defaults:** rst 3 cycles mid-LOAD → all outputs at reset values; a subsequent drain returns all-zero rows.
- **Overwrite with skew:** start, acc_mode=0, 10 consecutive beats with in_res column c = 100*c + t → row r column c reads 100*c + (2c+r). load_done pulses once, cycle 11.
- **Stalled load:** same stream with in_valid low every other cycle → identical bank contents; load_done after 20 cycles.
- **Accumulate and saturation:** second LOAD with acc_mode=1 adds 1 to every entry → values +1. A third pass adding 32767 clamps to 32767 and sets sat_flag. Feeding −32768 onto −1 clamps to −32768.
- **Back-pressure drain:** drain_req, out_ready toggling 1,0,0,1… → 4 rows in order, each held while stalled, out_last only on row 3. drain_clear=1 gives all-zero rows on a re-drain.
- **Simultaneous and ignored requests:** start and drain_req in the same IDLE cycle → LOAD entered. drain_req during LOAD and clear during DRAIN → no effect on state or data.
